hazard_scoreboard: RTL

Tracks in-flight register writes behind the instruction decoder and tells the ID stage whether the instruction currently decoding may issue and where each source operand must come from. It consumes the decoder's read/write register fields, keeps a three-entry shadow of the EX/MEM/WB pipeline, and drives the stall line and operand-forwarding selects for the ID/EX register. It sits between the decoder and the ID/EX pipeline register.

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 88 ++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decoder-side bundle between the ID stage and the hazard scoreboard
interface hazard_scoreboard_if;
    logic        id_valid;
    logic        read_en1;
    logic        read_en2;
    logic [3:0]  read_addr1;
    logic [3:0]  read_addr2;
    logic        reg_write;
    logic [3:0]  reg_addr;
    logic        mem_read;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [15:0] stall_cnt;

    // Decoder / ID stage side
    modport master (
        output id_valid, read_en1, read_en2, read_addr1, read_addr2,
        output reg_write, reg_addr, mem_read, flush,
        input  stall, fwd_sel1, fwd_sel2, stall_cnt
    );

    // Scoreboard side
    modport slave (
        input  id_valid, read_en1, read_en2, read_addr1, read_addr2,
        input  reg_write, reg_addr, mem_read, flush,
        output stall, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB write shadow driving ID stall and forwarding selects; FORWARD_EN enables bypassing
module hazard_scoreboard (
    input  logic                  clk,
    input  logic                  rst,
    hazard_scoreboard_if.slave    sb
);

    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
        logic       load;
    } entry_t;

    entry_t      ex_q;
    entry_t      mem_q;
    entry_t      wb_q;
    entry_t      ex_d;
    logic        h1_ex, h1_mem, h1_wb;
    logic        h2_ex, h2_mem, h2_wb;
    logic        stall_raw;
    logic        stall_c;
    logic [1:0]  fwd1_c;
    logic [1:0]  fwd2_c;
    logic [15:0] stall_cnt_q;
    logic        unused_load;

    function automatic logic hit(input logic en, input logic vld,
                                 input logic [3:0] a, input entry_t e);
        return en & vld & e.valid & (e.addr == a);
    endfunction

`ifdef FORWARD_EN
    function automatic logic [1:0] pick(input logic h_ex, input logic h_mem, input logic h_wb);
        if (h_ex)       return 2'b01;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        else            return 2'b00;
    endfunction
`endif

    // Source-vs-stage matches, stall decision and forwarding selects
    always_comb begin
        h1_ex  = hit(sb.read_en1, sb.id_valid, sb.read_addr1, ex_q);
        h1_mem = hit(sb.read_en1, sb.id_valid, sb.read_addr1, mem_q);
        h1_wb  = hit(sb.read_en1, sb.id_valid, sb.read_addr1, wb_q);
        h2_ex  = hit(sb.read_en2, sb.id_valid, sb.read_addr2, ex_q);
        h2_mem = hit(sb.read_en2, sb.id_valid, sb.read_addr2, mem_q);
        h2_wb  = hit(sb.read_en2, sb.id_valid, sb.read_addr2, wb_q);
`ifdef FORWARD_EN
        fwd1_c    = pick(h1_ex, h1_mem, h1_wb);
        fwd2_c    = pick(h2_ex, h2_mem, h2_wb);
        // Only a load still in EX cannot be bypassed: one bubble moves it to MEM
        stall_raw = (h1_ex | h2_ex) & ex_q.load;
`else
        fwd1_c    = 2'b00;
        fwd2_c    = 2'b00;
        // Without bypassing, wait until the producer has written the regfile
        stall_raw = h1_ex | h1_mem | h1_wb | h2_ex | h2_mem | h2_wb;
`endif
        stall_c = stall_raw & ~sb.flush;
        ex_d    = {sb.id_valid & sb.reg_write & ~stall_c & ~sb.flush, sb.reg_addr, sb.mem_read};
    end

    // Shift the pipeline shadow and count stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall_c && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // Load flags of older stages are tracked for completeness but never consumed
    assign unused_load = ex_q.load ^ mem_q.load ^ wb_q.load;

    assign sb.stall     = stall_c;
    assign sb.fwd_sel1  = fwd1_c;
    assign sb.fwd_sel2  = fwd2_c;
    assign sb.stall_cnt = stall_cnt_q;

endmodule
